// File: rtl/pcie_dma_burst_cmd_fifo_if.sv
// Command FIFO bus: producer write side, consumer FWFT read side, status and error flags.
// The master modport is the side that drives writes/pops; the FIFO attaches as slave.
interface pcie_dma_burst_cmd_fifo_if #(
  parameter int P_DATA_WIDTH  = 46,
  parameter int P_DEPTH_WIDTH = 5,
  parameter int P_ALLOC_WIDTH = 2
);
  logic                                   wr_en;
  logic [P_DATA_WIDTH-1:0]                wr_data;
  logic                                   full_n;
  logic                                   rd_en;
  logic [P_DATA_WIDTH-1:0]                rd_data;
  logic                                   rd_last;
  logic                                   empty_n;
  logic [P_DEPTH_WIDTH-P_ALLOC_WIDTH:0]   cmd_count;
  logic                                   almost_full;
  logic                                   overflow;
  logic                                   underflow;
  logic                                   err_clr;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  full_n, rd_data, rd_last, empty_n, cmd_count, almost_full, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output full_n, rd_data, rd_last, empty_n, cmd_count, almost_full, overflow, underflow
  );
endinterface

// File: rtl/pcie_dma_burst_cmd_fifo.sv
// Burst-atomic DMA command FIFO: commands become readable 2 cycles after their last word, FWFT read.
// Backpressure via full_n on command starts only (mid-command words always land); drops/empty pops set sticky flags.
module pcie_dma_burst_cmd_fifo #(
  parameter int P_DATA_WIDTH   = 46,
  parameter int P_DEPTH_WIDTH  = 5,
  parameter int P_ALLOC_WIDTH  = 2,
  parameter int P_AFULL_THRESH = 6
) (
  input logic                      clk_i,
  input logic                      rst_i,
  pcie_dma_burst_cmd_fifo_if.slave cmd_if
);
  localparam int PW    = P_DEPTH_WIDTH + 1;
  localparam int AW    = P_ALLOC_WIDTH;
  localparam int CW    = P_DEPTH_WIDTH - P_ALLOC_WIDTH + 1;
  localparam int NWORD = 1 << P_DEPTH_WIDTH;
  localparam logic [CW-1:0] SLOTS = CW'(1 << (CW - 1));
  localparam logic [CW-1:0] AFULL = CW'(P_AFULL_THRESH);

  logic [P_DATA_WIDTH-1:0] mem_q [NWORD];

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]           pend_ptr_q, pend_ptr_d;
  logic                    pend_q, pend_d;
  logic [CW-1:0]           cmd_count_q, cmd_count_d;
  logic                    full_n_q, full_n_d;
  logic                    almost_full_q, almost_full_d;
  logic                    empty_n_q, empty_n_d;
  logic                    overflow_q, overflow_d;
  logic                    underflow_q, underflow_d;
  logic                    rd_last_q, rd_last_d;
  logic [P_DATA_WIDTH-1:0] rd_data_q;

  logic                     wr_start, wr_acc, wr_end, pop;
  logic [CW-1:0]            wr_slot;
  logic [P_DEPTH_WIDTH-1:0] rd_addr;

  always_comb begin
    wr_start      = (wr_ptr_q[AW-1:0] == '0);
    wr_acc        = cmd_if.wr_en && (!wr_start || full_n_q);
    wr_end        = wr_acc && (&wr_ptr_q[AW-1:0]);
    pop           = cmd_if.rd_en && empty_n_q;
    wr_ptr_d      = wr_ptr_q + PW'(wr_acc);
    rd_ptr_d      = rd_ptr_q + PW'(pop);
    // Commit lags the last word by one edge; pend_ptr holds the end-of-command pointer meanwhile.
    pend_d        = wr_end;
    pend_ptr_d    = wr_end ? wr_ptr_d : pend_ptr_q;
    commit_ptr_d  = pend_q ? pend_ptr_q : commit_ptr_q;
    // A partially written command already owns its slot, so round the write slot up.
    wr_slot       = wr_ptr_d[PW-1:AW] + CW'(|wr_ptr_d[AW-1:0]);
    cmd_count_d   = wr_slot - rd_ptr_d[PW-1:AW];
    full_n_d      = (cmd_count_d < SLOTS);
    almost_full_d = (cmd_count_d >= AFULL);
    empty_n_d     = (rd_ptr_d != commit_ptr_q);
    rd_addr       = rd_ptr_d[P_DEPTH_WIDTH-1:0];
    rd_last_d     = &rd_ptr_d[AW-1:0];
    overflow_d    = (overflow_q && !cmd_if.err_clr) || (cmd_if.wr_en && wr_start && !full_n_q);
    underflow_d   = (underflow_q && !cmd_if.err_clr) || (cmd_if.rd_en && !empty_n_q);
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[P_DEPTH_WIDTH-1:0]] <= cmd_if.wr_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      pend_ptr_q    <= '0;
      pend_q        <= 1'b0;
      cmd_count_q   <= '0;
      full_n_q      <= 1'b1;
      almost_full_q <= 1'b0;
      empty_n_q     <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      rd_last_q     <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      pend_ptr_q    <= pend_ptr_d;
      pend_q        <= pend_d;
      cmd_count_q   <= cmd_count_d;
      full_n_q      <= full_n_d;
      almost_full_q <= almost_full_d;
      empty_n_q     <= empty_n_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      rd_last_q     <= rd_last_d;
      rd_data_q     <= mem_q[rd_addr];
    end
  end

  assign cmd_if.full_n      = full_n_q;
  assign cmd_if.rd_data     = rd_data_q;
  assign cmd_if.rd_last     = rd_last_q;
  assign cmd_if.empty_n     = empty_n_q;
  assign cmd_if.cmd_count   = cmd_count_q;
  assign cmd_if.almost_full = almost_full_q;
  assign cmd_if.overflow    = overflow_q;
  assign cmd_if.underflow   = underflow_q;
endmodule
